// File: rtl/serial_depacketizer.sv
// serial_depacketizer
//   Receive side of the serial link. Watches serial_in for 10-bit frames
//   (start=0, DATA_W data bits LSB first, stop=1), recovers each data word and
//   presents it through a one-deep valid/ready holding register. A bad stop bit
//   raises a one-cycle frame_err; a good frame that finds the holding register
//   full (and not draining) raises a one-cycle overrun and is dropped.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   serial_in  in   serial line, idles high
//   rx_ready   in   downstream ready
//   rx_data    out  recovered word, held while rx_valid=1
//   rx_valid   out  holding register full
//   rx_busy    out  frame reception in progress (state != IDLE)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, good frame lost to a full holding register
//   dbg_state  out  current FSM state, for observation only
//
// Configuration
//   RX_SYNC_EN  when defined, serial_in passes through a 2-flop synchronizer
//               (reset value 1); every sample point moves 2 cycles later.
//
// Handshake: a word transfers on every cycle where rx_valid & rx_ready are both
// high. rx_data never changes while rx_valid=1 and rx_ready=0; a word finishing
// on the same cycle as a transfer replaces the old one and rx_valid stays high.
module serial_depacketizer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              armed_q, armed_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              line;
  logic              drain;
  logic              wrap;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in};
  end

  assign line = sync_q[1];
`else
  assign line = serial_in;
`endif

  assign drain = valid_q & rx_ready;
  assign wrap  = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    armed_d = armed_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (drain) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // armed only after the line has been seen high, so a held-low break
        // cannot be mistaken for a stream of start bits
        if (line) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end
      START: begin
        if (cnt_q == CW'(HALF)) begin
          cnt_d   = '0;
          state_d = line ? IDLE : DATA;  // high at mid-start is a glitch
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_W-1:1]};
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (line) begin
            if (!valid_q || drain) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_depacketizer.sv
// Bench for serial_depacketizer: two instances (CLKS_PER_BIT=1 and 4) share
// clock and reset. Frames are described at word level; a reference model
// predicts, from each frame's start cycle and the bit-period arithmetic, when
// the stop bit is judged, and tracks the holding register and the stream of
// delivered words.
module tb_serial_depacketizer;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    int         t;     // cycle the start bit is first seen by the receiver
    int         e;     // cycle the frame is resolved (stop sample / false start)
    int         kind;  // 0 good, 1 bad stop, 2 false start
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line [2] = '{1'b1, 1'b1};
  logic       ready [2] = '{1'b0, 1'b0};
  logic [7:0] rx_data [2];
  logic       rx_valid [2];
  logic       rx_busy [2];
  logic       frame_err [2];
  logic       overrun [2];
  logic [1:0] dbg_state [2];

  int         rmode [2] = '{1, 1};  // 0 ready low, 1 ready high, 2 random
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  ev_t        ev_q [2][$];
  logic [7:0] exp_q [2][$];
  bit         mv [2], mf [2], mo [2], mb [2];
  logic [7:0] md [2];

  always #5 clk = ~clk;

  serial_depacketizer #(.CLKS_PER_BIT(1), .DATA_W(8)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .serial_in(line[0]), .rx_ready(ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_busy(rx_busy[0]),
    .frame_err(frame_err[0]), .overrun(overrun[0]), .dbg_state(dbg_state[0])
  );

  serial_depacketizer #(.CLKS_PER_BIT(4), .DATA_W(8)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .serial_in(line[1]), .rx_ready(ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_busy(rx_busy[1]),
    .frame_err(frame_err[1]), .overrun(overrun[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cpb_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int half_of(int i);
    return (cpb_of(i) - 1) / 2;
  endfunction

  // ---------------- reference model: one step per clock edge ----------------
  task automatic model_step(int i);
    bit  drain, load, f, o, b;
    ev_t e;
    drain = mv[i] && ready[i];
    load = 0; f = 0; o = 0; b = 0;
    e = '{0, 0, 0, 8'h00};
    if (ev_q[i].size() > 0) begin
      e = ev_q[i][0];
      if (cyc == e.e) begin
        if (e.kind == 0) begin
          if (!mv[i] || drain) load = 1;
          else                 o = 1;
        end else if (e.kind == 1) begin
          f = 1;
        end
        void'(ev_q[i].pop_front());
      end else if (cyc >= e.t) begin
        b = 1;
      end
    end
    if (load) begin
      mv[i] = 1;
      md[i] = e.d;
      exp_q[i].push_back(e.d);
    end else if (drain) begin
      mv[i] = 0;
    end
    mf[i] = f;
    mo[i] = o;
    mb[i] = b;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; mf[i] = 0; mo[i] = 0; mb[i] = 0; md[i] = 8'h00;
        ev_q[i].delete();
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
      cyc++;
    end
  end

  // ---------------- ready driver ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      case (rmode[i])
        0:       ready[i] = 1'b0;
        1:       ready[i] = 1'b1;
        default: ready[i] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- per-cycle checker / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid%0d", i), rx_valid[i], mv[i]);
      check($sformatf("busy%0d", i), rx_busy[i], mb[i]);
      check($sformatf("frame_err%0d", i), frame_err[i], mf[i]);
      check($sformatf("overrun%0d", i), overrun[i], mo[i]);
      if (mv[i]) check($sformatf("held_data%0d", i), rx_data[i], md[i]);
      if (rx_valid[i] && ready[i])
        check($sformatf("xfer_data%0d", i), rx_data[i],
              (exp_q[i].size() > 0) ? {24'h0, exp_q[i].pop_front()} : 32'hxxxxxxxx);
    end
  end

  // ---------------- line drivers ----------------
  task automatic drive_line(int i, logic v, int n);
    repeat (n) begin
      @(negedge clk);
      line[i] = v;
    end
  endtask

  // Drives the first nbits bits of a frame (10 for a full frame).
  task automatic send_frame(int i, logic [7:0] d, bit stop_ok, int nbits);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop_ok, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb_of(i); c++) begin
        @(negedge clk);
        line[i] = bits[b];
        if (b == 0 && c == 0) begin
          e.t    = cyc + SYNC_LAT;
          e.e    = e.t + half_of(i) + 9 * cpb_of(i);
          e.kind = stop_ok ? 0 : 1;
          e.d    = d;
          ev_q[i].push_back(e);
        end
      end
    end
  endtask

  // One-cycle low pulse on the line; the receiver rejects it at mid-start.
  task automatic glitch(int i);
    ev_t e;
    @(negedge clk);
    line[i] = 1'b0;
    e.t    = cyc + SYNC_LAT;
    e.e    = e.t + half_of(i);
    e.kind = 2;
    e.d    = 8'h00;
    ev_q[i].push_back(e);
    drive_line(i, 1'b1, 2);
  endtask

  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_data[i], 8'h00);
      check($sformatf("%s_valid%0d", tag, i), rx_valid[i], 1'b0);
      check($sformatf("%s_busy%0d", tag, i), rx_busy[i], 1'b0);
      check($sformatf("%s_ferr%0d", tag, i), frame_err[i], 1'b0);
      check($sformatf("%s_ovr%0d", tag, i), overrun[i], 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit prev_bad;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive_line(0, 1'b1, 3);

    // 0x4A with ready high: word appears 10 cycles after the start bit, one cycle
    send_frame(0, 8'h4A, 1'b1, 10);
    drive_line(0, 1'b1, 4);

    // back-to-back 0xA5, 0x3C with ready low: 0xA5 held, overrun on the second
    rmode[0] = 0;
    drive_line(0, 1'b1, 2);
    send_frame(0, 8'hA5, 1'b1, 10);
    send_frame(0, 8'h3C, 1'b1, 10);
    drive_line(0, 1'b1, 4);
    rmode[0] = 1;
    drive_line(0, 1'b1, 4);

    // bad stop, 20-cycle break, then a clean frame
    send_frame(0, 8'hFF, 1'b0, 10);
    drive_line(0, 1'b0, 20);
    drive_line(0, 1'b1, 2);
    send_frame(0, 8'h11, 1'b1, 10);
    drive_line(0, 1'b1, 4);

    // CLKS_PER_BIT=4: glitch, then full 0x81
    drive_line(1, 1'b1, 3);
    glitch(1);
    drive_line(1, 1'b1, 3);
    send_frame(1, 8'h81, 1'b1, 10);
    drive_line(1, 1'b1, 4);

    // reset while data bit 4 of 0x55 is on the line, then 0x66
    send_frame(0, 8'h55, 1'b1, 6);
    @(negedge clk);
    rst_n   = 1'b0;
    line[0] = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_line(0, 1'b1, 3);
    send_frame(0, 8'h66, 1'b1, 10);
    drive_line(0, 1'b1, 4);

    // randomized traffic with random back-pressure on both instances
    for (int i = 0; i < 2; i++) begin
      rmode[i] = 2;
      prev_bad = 0;
      for (int n = 0; n < 30; n++) begin
        int gap;
        bit ok;
        gap = $urandom_range(0, 3);
        if (prev_bad && gap == 0) gap = 1;
        if (gap > 0) drive_line(i, 1'b1, gap);
        if (i == 1 && $urandom_range(0, 5) == 0) glitch(i);
        ok = ($urandom_range(0, 7) != 0);
        send_frame(i, 8'($urandom_range(0, 255)), ok, 10);
        prev_bad = !ok;
      end
      drive_line(i, 1'b1, 2);
    end

    rmode[0] = 1;
    rmode[1] = 1;
    drive_line(0, 1'b1, 20);
    check("leftover0", exp_q[0].size(), 0);
    check("leftover1", exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
